// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-write arbiter family: state encoding,
// default sizing and the beat-counter width.
package reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

  // Wide enough for MAX_BURST up to 15.
  localparam int unsigned BEAT_W = 4;

endpackage

// File: rtl/reg_write_arbiter_dff_en_bank.sv
// WIDTH-bit D flip-flop bank with write enable and synchronous active-low clear.
module dff_en_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that sequences request/grant/ack writes from NREQ
// producers into one shared register, with optional locked bursts.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_in,
  input  logic [NREQ-1:0]       lock_in,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt_out,
  output logic [NREQ-1:0]       ack_out,
  output logic [WIDTH-1:0]      q_out,
  output logic                  busy_out
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [BEAT_W:0] MAX_BURST_L = (BEAT_W + 1)'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [IDX_W-1:0]  pick;
  logic              pick_valid;
  logic [IDX_W-1:0]  ptr_after_win;
  logic [BEAT_W:0]   beat_next;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;

  // Rotating priority: the first requester found scanning up from ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = ptr_q;
    pick_valid = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (!pick_valid && req_in[idx]) begin
        pick       = IDX_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  assign ptr_after_win = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
  assign beat_next     = {1'b0, beat_q} + (BEAT_W + 1)'(1);
  assign wr_data       = data_in[int'(win_q) * int'(WIDTH) +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    wr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_GRANT;
          win_d       = pick;
          beat_d      = '0;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end

      ST_GRANT: begin
        if (req_in[win_q]) begin
          wr_en        = 1'b1;
          ack_d[win_q] = 1'b1;
          beat_d       = beat_next[BEAT_W-1:0];
        end
        // A dropped request is an abandon: release exactly like a final beat.
        if (!(req_in[win_q] && lock_in[win_q] && (beat_next < MAX_BURST_L))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_after_win;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it only takes effect on a clock edge and
  // rst_n is a plain data input to these flops rather than a sensitivity item.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      beat_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  dff_en_bank #(.WIDTH(WIDTH)) u_q_bank (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (wr_en),
    .d     (wr_data),
    .q     (q_out)
  );

  assign gnt_out  = gnt_q;
  assign ack_out  = ack_q;
  assign busy_out = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a random
// run compared against a transaction-level reference model.
module tb_reg_write_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_in;
  logic [NREQ-1:0]       lock_in;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt_out;
  logic [NREQ-1:0]       ack_out;
  logic [WIDTH-1:0]      q_out;
  logic                  busy_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .lock_in  (lock_in),
    .data_in  (data_in),
    .gnt_out  (gnt_out),
    .ack_out  (ack_out),
    .q_out    (q_out),
    .busy_out (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the register, how many writes it has done,
  // and where the next round-robin search starts.
  bit              m_busy  = 1'b0;
  int              m_owner = 0;
  int              m_beats = 0;
  int              m_ptr   = 0;
  logic [NREQ-1:0] m_gnt   = '0;
  logic [NREQ-1:0] m_ack   = '0;
  logic [WIDTH-1:0] m_q    = '0;

  task automatic model_release();
    m_busy = 1'b0;
    m_gnt  = '0;
    m_ptr  = (m_owner + 1) % NREQ;
  endtask

  task automatic model_step(input logic rst, input logic [NREQ-1:0] req,
                            input logic [NREQ-1:0] lock,
                            input logic [NREQ*WIDTH-1:0] data);
    bit found;
    int cand;
    if (!rst) begin
      m_busy = 1'b0; m_owner = 0; m_beats = 0; m_ptr = 0;
      m_gnt = '0; m_ack = '0; m_q = '0;
    end else if (!m_busy) begin
      m_ack = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (!found && req[cand]) begin
          found   = 1'b1;
          m_owner = cand;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_beats = 0;
        m_gnt   = '0;
        m_gnt[m_owner] = 1'b1;
      end
    end else begin
      m_ack = '0;
      if (req[m_owner]) begin
        m_q = data[m_owner*WIDTH +: WIDTH];
        m_ack[m_owner] = 1'b1;
        m_beats++;
        if (!(lock[m_owner] && m_beats < MAX_BURST)) model_release();
      end else begin
        model_release();
      end
    end
  endtask

  // One clock: the model consumes the same inputs the DUT samples, then
  // outputs are settled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(rst_n, req_in, lock_in, data_in);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
    data_in[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = '0; lock_in = '0; data_in = '0;
    tick(); tick();
    total_cnt++; if (gnt_out !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt_out); else pass_cnt++;
    total_cnt++; if (ack_out !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack_out); else pass_cnt++;
    total_cnt++; if (q_out !== 8'h00) $display("FAIL reset_q: got %h want 00", q_out); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (gnt_out !== 4'b0000) $display("FAIL reset_idle_hold: got %b want 0000", gnt_out); else pass_cnt++;
  endtask

  task automatic test_single_write();
    req_in = 4'b0100; set_lane(2, 8'h3C);
    tick();
    total_cnt++; if (gnt_out !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt_out); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_out); else pass_cnt++;
    total_cnt++; if (ack_out !== 4'b0000) $display("FAIL single_early_ack: got %b want 0000", ack_out); else pass_cnt++;
    tick();
    total_cnt++; if (q_out !== 8'h3C) $display("FAIL single_q: got %h want 3c", q_out); else pass_cnt++;
    total_cnt++; if (ack_out !== 4'b0100) $display("FAIL single_ack: got %b want 0100", ack_out); else pass_cnt++;
    total_cnt++; if (gnt_out !== 4'b0000) $display("FAIL single_gnt_drop: got %b want 0000", gnt_out); else pass_cnt++;
    req_in = '0;
    tick();
    total_cnt++; if (ack_out !== 4'b0000) $display("FAIL single_ack_pulse: got %b want 0000", ack_out); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]  exp_g;
    logic [WIDTH-1:0] exp_q;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, 8'h10 + 8'(i));
    req_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = '0; exp_g[i % NREQ] = 1'b1;
      exp_q = 8'h10 + 8'(i % NREQ);
      tick();
      total_cnt++; if (gnt_out !== exp_g) $display("FAIL rr_gnt_%0d: got %b want %b", i, gnt_out, exp_g); else pass_cnt++;
      tick();
      total_cnt++; if (ack_out !== exp_g) $display("FAIL rr_ack_%0d: got %b want %b", i, ack_out, exp_g); else pass_cnt++;
      total_cnt++; if (q_out !== exp_q) $display("FAIL rr_q_%0d: got %h want %h", i, q_out, exp_q); else pass_cnt++;
    end
  endtask

  task automatic test_locked_burst();
    logic [NREQ-1:0] exp_g;
    req_in = 4'b1010; lock_in = 4'b0010; set_lane(1, 8'h01);
    tick();
    total_cnt++; if (gnt_out !== 4'b0010) $display("FAIL burst_gnt: got %b want 0010", gnt_out); else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      set_lane(1, 8'(k));
      tick();
      exp_g = (k < MAX_BURST) ? 4'b0010 : 4'b0000;
      total_cnt++; if (ack_out !== 4'b0010) $display("FAIL burst_ack_%0d: got %b want 0010", k, ack_out); else pass_cnt++;
      total_cnt++; if (q_out !== 8'(k)) $display("FAIL burst_q_%0d: got %h want %h", k, q_out, 8'(k)); else pass_cnt++;
      total_cnt++; if (gnt_out !== exp_g) $display("FAIL burst_gnt_%0d: got %b want %b", k, gnt_out, exp_g); else pass_cnt++;
    end
    set_lane(1, 8'h05);
    tick();
    total_cnt++; if (gnt_out !== 4'b1000) $display("FAIL burst_next_gnt: got %b want 1000", gnt_out); else pass_cnt++;
    total_cnt++; if (ack_out !== 4'b0000) $display("FAIL burst_no_fifth_ack: got %b want 0000", ack_out); else pass_cnt++;
    req_in = 4'b1000;
    tick();
    total_cnt++; if (ack_out !== 4'b1000) $display("FAIL burst_next_ack: got %b want 1000", ack_out); else pass_cnt++;
    total_cnt++; if (q_out !== 8'h13) $display("FAIL burst_next_q: got %h want 13", q_out); else pass_cnt++;
    req_in = '0; lock_in = '0;
  endtask

  task automatic test_abandon();
    req_in = 4'b1000;
    tick();
    total_cnt++; if (gnt_out !== 4'b1000) $display("FAIL abandon_gnt: got %b want 1000", gnt_out); else pass_cnt++;
    req_in = 4'b1001; set_lane(3, 8'hEE);
    req_in[3] = 1'b0;
    tick();
    total_cnt++; if (ack_out !== 4'b0000) $display("FAIL abandon_ack: got %b want 0000", ack_out); else pass_cnt++;
    total_cnt++; if (q_out !== 8'h13) $display("FAIL abandon_q: got %h want 13", q_out); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL abandon_busy: got %b want 0", busy_out); else pass_cnt++;
    req_in = 4'b1001;
    tick();
    total_cnt++; if (gnt_out !== 4'b0001) $display("FAIL abandon_ptr_gnt: got %b want 0001", gnt_out); else pass_cnt++;
    req_in = 4'b0001;
    tick();
    total_cnt++; if (q_out !== 8'h10) $display("FAIL abandon_next_q: got %h want 10", q_out); else pass_cnt++;
    req_in = '0;
  endtask

  task automatic test_simultaneous();
    req_in = 4'b1001; lock_in = 4'b1000;
    tick();
    total_cnt++; if (gnt_out !== 4'b1000) $display("FAIL simul_gnt: got %b want 1000", gnt_out); else pass_cnt++;
    req_in = 4'b1111;
    tick();
    total_cnt++; if (gnt_out !== 4'b1000) $display("FAIL simul_hold_1: got %b want 1000", gnt_out); else pass_cnt++;
    total_cnt++; if (ack_out !== 4'b1000) $display("FAIL simul_ack_1: got %b want 1000", ack_out); else pass_cnt++;
    tick();
    total_cnt++; if (gnt_out !== 4'b1000) $display("FAIL simul_hold_2: got %b want 1000", gnt_out); else pass_cnt++;
    lock_in = '0;
    tick();
    total_cnt++; if (gnt_out !== 4'b0000) $display("FAIL simul_release: got %b want 0000", gnt_out); else pass_cnt++;
    total_cnt++; if (ack_out !== 4'b1000) $display("FAIL simul_last_ack: got %b want 1000", ack_out); else pass_cnt++;
    req_in = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req_in = 4'b0010; lock_in = 4'b0010; set_lane(1, 8'hA5);
    tick(); tick();
    total_cnt++; if (q_out !== 8'hA5) $display("FAIL rstmid_pre_q: got %h want a5", q_out); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++; if (ack_out !== 4'b0000) $display("FAIL rstmid_ack: got %b want 0000", ack_out); else pass_cnt++;
    tick();
    total_cnt++; if (q_out !== 8'h00) $display("FAIL rstmid_q: got %h want 00", q_out); else pass_cnt++;
    total_cnt++; if (gnt_out !== 4'b0000) $display("FAIL rstmid_gnt: got %b want 0000", gnt_out); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_out); else pass_cnt++;
    rst_n = 1'b1; req_in = '0; lock_in = '0;
    tick();
    total_cnt++; if (q_out !== 8'h00) $display("FAIL rstmid_after_q: got %h want 00", q_out); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n   = ($urandom_range(0, 59) != 0);
      req_in  = NREQ'($urandom);
      lock_in = NREQ'($urandom);
      data_in = ($urandom_range(0, 3) == 0) ? (NREQ*WIDTH)'($urandom) : data_in;
      tick();
      total_cnt++; if (gnt_out !== m_gnt) $display("FAIL rand_gnt@%0d: got %b want %b", c, gnt_out, m_gnt); else pass_cnt++;
      total_cnt++; if (ack_out !== m_ack) $display("FAIL rand_ack@%0d: got %b want %b", c, ack_out, m_ack); else pass_cnt++;
      total_cnt++; if (q_out !== m_q) $display("FAIL rand_q@%0d: got %h want %h", c, q_out, m_q); else pass_cnt++;
      total_cnt++; if (busy_out !== m_busy) $display("FAIL rand_busy@%0d: got %b want %b", c, busy_out, m_busy); else pass_cnt++;
    end
    rst_n = 1'b1; req_in = '0; lock_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; lock_in = '0; data_in = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_locked_burst();
    test_abandon();
    test_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
